counter_run_scheduler: RTL
==========================

Name: counter_run_scheduler

Overview:
Controller that shares one FSM_counter datapath between two requesters. It arbitrates between the requesters round-robin, latches the granted requester's target count and skip option, and drives the counter's start and skip inputs. It watches count_out until the target is reached or a timeout expires, then drains the counter before serving the next request. It sits between the requesting logic and the counter instance, which receives only ctr_start and ctr_skip from this block.

Parameters:
CW, 8, counter width; matches count_out.
TIMEOUT, 1023, max RUN cycles before abort; must be >= 1.
DRAIN_CYC, 4, cycles ctr_start is held low after a run; must be >= 1.

Ports:
clk  in  1  clock; all logic on rising edge.
rstn  in  1  synchronous active-low reset.
req  in  2  per-requester request; held high until done/err.
tgt0  in  CW  requester 0 target count.
tgt1  in  CW  requester 1 target count.
skip_req  in  2  per-requester request to assert counter skip.
gnt  out  2  one-hot grant; high for the whole GRANT/RUN of the owner.
done  out  2  one-cycle pulse: target reached.
err  out  2  one-cycle pulse: timeout.
busy  out  1  high in any state other than IDLE.
ctr_start  out  1  to counter start.
ctr_skip  out  1  to counter skip.
ctr_count  in  CW  from counter count_out.
ctr_skip_to_five  in  1  from counter skip_to_five.

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE.
- Reset value of every output: gnt, done, err, ctr_start, ctr_skip and busy are 0. Last-served pointer resets so that requester 0 wins first.
- Reset mid-run takes effect on the next edge with no done/err pulse.
- States: IDLE, GRANT, RUN, DRAIN.
- IDLE: if any req is high, pick the winner and go to GRANT. The requester that was not served last wins; a lone requester always wins. Latch tgt and skip_req[w] into registers.
- GRANT (1 cycle): gnt[w]=1; timeout counter cleared. If the latched target equals 0, pulse done[w] and go to DRAIN without asserting ctr_start. Otherwise go to RUN.
- RUN: ctr_start=1; gnt[w]=1; the timeout counter increments each cycle.
  - ctr_skip=1 while the skip latch is set. The latch clears on the cycle after ctr_skip_to_five is first seen high.
  - Completion has priority over timeout. When registered ctr_count == latched tgt, pulse done[w] and go to DRAIN.
  - Otherwise, when the timeout counter reaches TIMEOUT, pulse err[w] and go to DRAIN.
  - If req[w] drops, abort: go to DRAIN with no done/err.
- Pulse timing: done/err assert in the same cycle that gnt drops and ctr_start/ctr_skip go 0.
- DRAIN: ctr_start=0, ctr_skip=0, gnt=0. Wait DRAIN_CYC cycles, then go to IDLE and update the last-served pointer.
- Requests arriving outside IDLE are held off, not lost.
- Latency: req seen at edge N → gnt at N+1 → ctr_start at N+2.
- Width rule: compare at the full CW width; no wrap handling inside the scheduler.
- Target unreachable (counter wraps past it): resolved by the timeout.
- Requester must hold tgt/skip_req stable only until gnt rises; the values are latched.

Decomposition:
- Shared package: state encoding constants (IDLE, GRANT, RUN, DRAIN) and default CW/TIMEOUT/DRAIN_CYC.
- Natural sub-module: rr_arbiter2, a 2-way round-robin with a last-served pointer and an update strobe.
- Timeout and drain counters stay inline.

Test Plan:
- Reset hold 10 cycles with req=2'b11 → all outputs 0. After release: gnt=2'b01 first, ctr_start rises 2 cycles after req.
- req0, tgt0=8'd20, counter model counting → done[0] single pulse when count_out=20. ctr_start low for 4 cycles, then busy=0.
- req=2'b11 continuously, tgt=5 each → grants alternate 01,10,01,10. No gnt overlap; each done pulse matches the grant.
- skip_req[1]=1, model raises skip_to_five at run cycle 3 → ctr_skip high through that cycle, low from the next; run still completes with done[1].
- tgt0=8'd0 → done[0] in the GRANT cycle, ctr_start never asserts.
- Model stalled (count stays 0), TIMEOUT=16 → err[0] after 16 RUN cycles, no done. Then req0 drop mid-run → DRAIN, no pulses. Then rstn low mid-RUN → outputs 0 at the next edge.

Source files
------------

// File: rtl/counter_run_scheduler_pkg.sv
// Shared state encoding, parameter defaults and helpers for the counter run scheduler.
package counter_run_scheduler_pkg;

    localparam int CW_DEF        = 8;
    localparam int TIMEOUT_DEF   = 1023;
    localparam int DRAIN_CYC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/counter_run_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: the requester not served last wins a tie.
module counter_run_scheduler_rr_arbiter2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       win_valid,
    output logic       win_idx
);

    logic last_r;

    // Last-served pointer; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_r <= 1'b1;
        end else if (upd) begin
            last_r <= upd_idx;
        end else begin
            last_r <= last_r;
        end
    end

    // Winner selection from the current request vector.
    always_comb begin
        win_valid = |req;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_r;
            default: win_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/counter_run_scheduler.sv
// Shares one counter between two requesters: arbitrates, runs the counter to the
// latched target or a timeout, then drains it before serving the next request.
module counter_run_scheduler
    import counter_run_scheduler_pkg::*;
#(
    parameter int CW        = CW_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    req,
    input  logic [CW-1:0] tgt0,
    input  logic [CW-1:0] tgt1,
    input  logic [1:0]    skip_req,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [1:0]    err,
    output logic          busy,
    output logic          ctr_start,
    output logic          ctr_skip,
    input  logic [CW-1:0] ctr_count,
    input  logic          ctr_skip_to_five
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    sched_state_t  state_r, state_n;
    logic          own_r, own_n;
    logic [CW-1:0] tgt_r, tgt_n;
    logic          skip_r, skip_n;
    logic [CW-1:0] count_r;
    logic [TW-1:0] to_cnt_r, to_cnt_n;
    logic [DW-1:0] dr_cnt_r, dr_cnt_n;
    logic [1:0]    done_n, err_n;
    logic          upd_s;
    logic          win_valid_s, win_idx_s;

    counter_run_scheduler_rr_arbiter2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .upd       (upd_s),
        .upd_idx   (own_r),
        .win_valid (win_valid_s),
        .win_idx   (win_idx_s)
    );

    // Next-state, latch and pulse decisions.
    always_comb begin
        state_n  = state_r;
        own_n    = own_r;
        tgt_n    = tgt_r;
        skip_n   = skip_r;
        to_cnt_n = to_cnt_r;
        dr_cnt_n = dr_cnt_r;
        done_n   = 2'b00;
        err_n    = 2'b00;
        upd_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_n = ST_GRANT;
                    own_n   = win_idx_s;
                    tgt_n   = win_idx_s ? tgt1 : tgt0;
                    skip_n  = skip_req[win_idx_s];
                    // A zero target completes immediately, so its done pulse
                    // coincides with the single GRANT cycle.
                    if (tgt_n == {CW{1'b0}}) begin
                        done_n = onehot2(win_idx_s);
                    end else begin
                        done_n = 2'b00;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                to_cnt_n = {TW{1'b0}};
                dr_cnt_n = {DW{1'b0}};
                if (tgt_r == {CW{1'b0}}) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                to_cnt_n = to_cnt_r + TW'(1);
                skip_n   = skip_r & ~ctr_skip_to_five;
                if (count_r == tgt_r) begin
                    done_n  = onehot2(own_r);
                    state_n = ST_DRAIN;
                end else if (to_cnt_n == TO_LIMIT) begin
                    err_n   = onehot2(own_r);
                    state_n = ST_DRAIN;
                end else if (!req[own_r]) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (dr_cnt_r == DRAIN_LAST) begin
                    state_n  = ST_IDLE;
                    dr_cnt_n = {DW{1'b0}};
                    upd_s    = 1'b1;
                end else begin
                    dr_cnt_n = dr_cnt_r + DW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, latches and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            own_r     <= 1'b0;
            tgt_r     <= {CW{1'b0}};
            skip_r    <= 1'b0;
            count_r   <= {CW{1'b0}};
            to_cnt_r  <= {TW{1'b0}};
            dr_cnt_r  <= {DW{1'b0}};
            gnt       <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            busy      <= 1'b0;
            ctr_start <= 1'b0;
            ctr_skip  <= 1'b0;
        end else begin
            state_r   <= state_n;
            own_r     <= own_n;
            tgt_r     <= tgt_n;
            skip_r    <= skip_n;
            count_r   <= ctr_count;
            to_cnt_r  <= to_cnt_n;
            dr_cnt_r  <= dr_cnt_n;
            gnt       <= ((state_n == ST_GRANT) || (state_n == ST_RUN)) ? onehot2(own_n) : 2'b00;
            done      <= done_n;
            err       <= err_n;
            busy      <= (state_n != ST_IDLE);
            ctr_start <= (state_n == ST_RUN);
            ctr_skip  <= (state_n == ST_RUN) && skip_n;
        end
    end

endmodule
